// File: rtl/aes_ctrl_pkg.sv
// Shared definitions for the AES-128 round controller: FSM states, mux2 encodings
// and the per-round step order for each direction.
package aes_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADD,
        ST_SUB,
        ST_SHIFT,
        ST_MIX,
        ST_KEY,
        ST_FIN
    } state_e;

    localparam logic [1:0] MUX2_INIT  = 2'b00;
    localparam logic [1:0] MUX2_MID   = 2'b01;
    localparam logic [1:0] MUX2_FINAL = 2'b10;

    localparam int STEPS_PER_ROUND = 5;

    // Step order inside rounds 1..NR, indexed by position 0..4.
    function automatic state_e step_at(input logic dec, input logic [2:0] pos);
        state_e s;
        s = ST_ADD;
        if (!dec) begin
            case (pos)
                3'd0:    s = ST_KEY;
                3'd1:    s = ST_SUB;
                3'd2:    s = ST_SHIFT;
                3'd3:    s = ST_MIX;
                default: s = ST_ADD;
            endcase
        end else begin
            case (pos)
                3'd0:    s = ST_KEY;
                3'd1:    s = ST_SHIFT;
                3'd2:    s = ST_SUB;
                3'd3:    s = ST_ADD;
                default: s = ST_MIX;
            endcase
        end
        return s;
    endfunction

    // Strobe vector layout: {add, sub, shift, mix, key}.
    function automatic logic [4:0] step_strobe(input state_e s);
        logic [4:0] v;
        case (s)
            ST_ADD:   v = 5'b10000;
            ST_SUB:   v = 5'b01000;
            ST_SHIFT: v = 5'b00100;
            ST_MIX:   v = 5'b00010;
            ST_KEY:   v = 5'b00001;
            default:  v = 5'b00000;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/aes_rcon_rom.sv
// AES key-schedule round constant lookup; indices outside 1..10 return zero.
module aes_rcon_rom (
    input  logic [3:0] idx,
    output logic [7:0] rcon
);

    always_comb begin
        rcon = 8'h00;
        case (idx)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1B;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

endmodule

// File: rtl/aes_round_sequencer.sv
// AES-128 round controller: sequences step strobes, datapath mux selects and Rcon
// for encrypt or decrypt, with stall, abort and a one-deep queued start.
module aes_round_sequencer
    import aes_ctrl_pkg::*;
#(
    parameter int NR   = 10,
    parameter int RC_W = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic            decrypt,
    input  logic            stall,
    input  logic            abort,
    output logic            busy,
    output logic            done,
    output logic [3:0]      round_idx,
    output logic            add_start,
    output logic            sub_start,
    output logic            shift_start,
    output logic            mix_start,
    output logic            key_start,
    output logic            mux1_sel,
    output logic [1:0]      mux2_sel,
    output logic [RC_W-1:0] key_rc
);

    localparam logic [3:0] NR_L = 4'(NR);

    state_e          state_q, state_d;
    logic [3:0]      round_q, round_d;
    logic [2:0]      pos_q, pos_d;
    logic            mode_q, mode_d;
    logic            pend_q, pend_d;
    logic            pend_dec_q, pend_dec_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [4:0]      stb_q, stb_d;
    logic            mux1_q, mux1_d;
    logic [1:0]      mux2_q, mux2_d;
    logic [RC_W-1:0] key_rc_q, key_rc_d;

    logic [3:0]      nxt_pos;
    logic [3:0]      nxt_round;
    logic            nxt_fin;
    state_e          nxt_step;
    logic [3:0]      rc_idx;
    logic [7:0]      rcon;
    logic            launch;
    logic            launch_dec;
    logic            issue;

    aes_rcon_rom u_rcon (
        .idx  (rc_idx),
        .rcon (rcon)
    );

    // Successor of the step just issued. Round 0 parks at position 4 so its
    // successor is the first step of round 1; MIX is skipped in the final round.
    always_comb begin
        nxt_pos   = {1'b0, pos_q} + 4'd1;
        nxt_round = round_q;
        nxt_fin   = 1'b0;
        if (nxt_pos <= 4'd4 && round_q == NR_L && step_at(mode_q, nxt_pos[2:0]) == ST_MIX) begin
            nxt_pos = nxt_pos + 4'd1;
        end
        if (nxt_pos > 4'd4) begin
            nxt_pos = 4'd0;
            if (round_q == NR_L) begin
                nxt_fin = 1'b1;
            end else begin
                nxt_round = round_q + 4'd1;
            end
        end
        nxt_step = step_at(mode_q, nxt_pos[2:0]);
        rc_idx   = mode_q ? (NR_L + 4'd1 - nxt_round) : nxt_round;
    end

    always_comb begin
        state_d    = state_q;
        round_d    = round_q;
        pos_d      = pos_q;
        mode_d     = mode_q;
        pend_d     = pend_q;
        pend_dec_d = pend_dec_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        mux1_d     = mux1_q;
        mux2_d     = mux2_q;
        key_rc_d   = key_rc_q;
        launch     = 1'b0;
        launch_dec = 1'b0;
        issue      = 1'b0;

        if (state_q == ST_IDLE) begin
            if (start && !abort) begin
                launch     = 1'b1;
                launch_dec = decrypt;
            end
        end else if (abort) begin
            state_d = ST_IDLE;
            round_d = 4'd0;
            pos_d   = 3'd0;
            pend_d  = 1'b0;
            busy_d  = 1'b0;
            mux1_d  = 1'b0;
            mux2_d  = MUX2_INIT;
        end else if (state_q == ST_FIN) begin
            if (pend_q) begin
                launch     = 1'b1;
                launch_dec = pend_dec_q;
                pend_d     = 1'b0;
            end else if (start) begin
                launch     = 1'b1;
                launch_dec = decrypt;
            end else begin
                state_d = ST_IDLE;
            end
        end else begin
            if (start && !pend_q) begin
                pend_d     = 1'b1;
                pend_dec_d = decrypt;
            end
            if (!stall) begin
                if (nxt_fin) begin
                    state_d = ST_FIN;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    round_d = 4'd0;
                    pos_d   = 3'd0;
                    mux1_d  = 1'b0;
                    mux2_d  = MUX2_INIT;
                end else begin
                    state_d = nxt_step;
                    pos_d   = nxt_pos[2:0];
                    round_d = nxt_round;
                    issue   = 1'b1;
                    if (nxt_step == ST_KEY) begin
                        key_rc_d               = '0;
                        key_rc_d[RC_W-1 -: 8]  = rcon;
                        mux1_d                 = 1'b1;
                        mux2_d                 = (nxt_round == NR_L) ? MUX2_FINAL : MUX2_MID;
                    end
                end
            end
        end

        if (launch) begin
            state_d = ST_ADD;
            round_d = 4'd0;
            pos_d   = 3'd4;
            mode_d  = launch_dec;
            busy_d  = 1'b1;
            mux1_d  = 1'b0;
            mux2_d  = MUX2_INIT;
            issue   = 1'b1;
        end

        stb_d = issue ? step_strobe(state_d) : 5'b00000;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            round_q    <= 4'd0;
            pos_q      <= 3'd0;
            mode_q     <= 1'b0;
            pend_q     <= 1'b0;
            pend_dec_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            stb_q      <= 5'b00000;
            mux1_q     <= 1'b0;
            mux2_q     <= MUX2_INIT;
            key_rc_q   <= '0;
        end else begin
            state_q    <= state_d;
            round_q    <= round_d;
            pos_q      <= pos_d;
            mode_q     <= mode_d;
            pend_q     <= pend_d;
            pend_dec_q <= pend_dec_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            stb_q      <= stb_d;
            mux1_q     <= mux1_d;
            mux2_q     <= mux2_d;
            key_rc_q   <= key_rc_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign round_idx   = round_q;
    assign add_start   = stb_q[4];
    assign sub_start   = stb_q[3];
    assign shift_start = stb_q[2];
    assign mix_start   = stb_q[1];
    assign key_start   = stb_q[0];
    assign mux1_sel    = mux1_q;
    assign mux2_sel    = mux2_q;
    assign key_rc      = key_rc_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench for aes_round_sequencer: an NR=10 and an NR=2 instance share stimulus;
// per-cycle outputs are logged and checked against hand-computed cycle numbers.
module tb_aes_round_sequencer;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0;
    logic decrypt = 1'b0;
    logic stall = 1'b0;
    logic abort = 1'b0;

    logic        busy1, done1, add1, sub1, shf1, mix1, key1, m1_1;
    logic [3:0]  rnd1;
    logic [1:0]  m2_1;
    logic [31:0] rc1;
    logic        busy2, done2, add2, sub2, shf2, mix2, key2, m1_2;
    logic [3:0]  rnd2;
    logic [1:0]  m2_2;
    logic [31:0] rc2;

    always #5 clk = ~clk;

    aes_round_sequencer #(.NR(10), .RC_W(32)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .start(start), .decrypt(decrypt),
        .stall(stall), .abort(abort), .busy(busy1), .done(done1), .round_idx(rnd1),
        .add_start(add1), .sub_start(sub1), .shift_start(shf1), .mix_start(mix1),
        .key_start(key1), .mux1_sel(m1_1), .mux2_sel(m2_1), .key_rc(rc1)
    );

    aes_round_sequencer #(.NR(2), .RC_W(32)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .start(start), .decrypt(decrypt),
        .stall(stall), .abort(abort), .busy(busy2), .done(done2), .round_idx(rnd2),
        .add_start(add2), .sub_start(sub2), .shift_start(shf2), .mix_start(mix2),
        .key_start(key2), .mux1_sel(m1_2), .mux2_sel(m2_2), .key_rc(rc2)
    );

    localparam int MAXC = 200;
    localparam logic [4:0] S_ADD = 5'b10000, S_SUB = 5'b01000, S_SHF = 5'b00100,
                           S_MIX = 5'b00010, S_KEY = 5'b00001;
    localparam logic [24:0] ENC_RND = {S_KEY, S_SUB, S_SHF, S_MIX, S_ADD};
    localparam logic [24:0] DEC_RND = {S_KEY, S_SHF, S_SUB, S_ADD, S_MIX};
    localparam logic [79:0] ENC_RC  = 80'h01020408102040801B36;
    localparam logic [79:0] DEC_RC  = 80'h361B8040201008040201;

    logic       s_start [MAXC];
    logic       s_dec   [MAXC];
    logic       s_stall [MAXC];
    logic       s_abort [MAXC];
    logic       s_rst   [MAXC];
    logic [4:0] lg_stb  [MAXC];
    logic       lg_done [MAXC];
    logic       lg_busy [MAXC];
    logic       lg_any  [MAXC];
    logic [7:0] lg_rc   [MAXC];
    logic       lg_m1   [MAXC];
    logic [1:0] lg_m2   [MAXC];
    logic [3:0] lg_rnd  [MAXC];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        for (int k = 0; k < MAXC; k++) begin
            s_start[k] = 1'b0; s_dec[k] = 1'b0; s_stall[k] = 1'b0;
            s_abort[k] = 1'b0; s_rst[k] = 1'b0;
        end
    endtask

    // Cycle k: outputs sampled at its falling edge, then inputs for edge k+1 driven.
    task automatic run(input int n, input bit sel);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (!sel) begin
                lg_stb[k]  = {add1, sub1, shf1, mix1, key1};
                lg_done[k] = done1; lg_busy[k] = busy1; lg_rc[k] = rc1[31:24];
                lg_m1[k]   = m1_1;  lg_m2[k]   = m2_1;  lg_rnd[k] = rnd1;
                lg_any[k]  = |{busy1, done1, rnd1, add1, sub1, shf1, mix1, key1, m1_1, m2_1, rc1};
            end else begin
                lg_stb[k]  = {add2, sub2, shf2, mix2, key2};
                lg_done[k] = done2; lg_busy[k] = busy2; lg_rc[k] = rc2[31:24];
                lg_m1[k]   = m1_2;  lg_m2[k]   = m2_2;  lg_rnd[k] = rnd2;
                lg_any[k]  = |{busy2, done2, rnd2, add2, sub2, shf2, mix2, key2, m1_2, m2_2, rc2};
            end
            start   = s_start[k];
            decrypt = s_dec[k];
            stall   = s_stall[k];
            abort   = s_abort[k];
            reset_n = !s_rst[k];
        end
    endtask

    function automatic int cnt_bit(input int b, input int lo, input int hi);
        int c = 0;
        for (int k = lo; k <= hi; k++) if (b > 4 ? (|lg_stb[k]) : lg_stb[k][b]) c++;
        return c;
    endfunction

    function automatic int cnt_done(input int lo, input int hi);
        int c = 0;
        for (int k = lo; k <= hi; k++) if (lg_done[k]) c++;
        return c;
    endfunction

    function automatic int first_done(input int lo, input int hi);
        for (int k = lo; k <= hi; k++) if (lg_done[k]) return k;
        return -1;
    endfunction

    function automatic int cnt_overlap(input int lo, input int hi);
        int c = 0;
        for (int k = lo; k <= hi; k++) if ($countones(lg_stb[k]) > 1) c++;
        return c;
    endfunction

    function automatic logic [24:0] seq5(input int k);
        return {lg_stb[k], lg_stb[k+1], lg_stb[k+2], lg_stb[k+3], lg_stb[k+4]};
    endfunction

    function automatic logic [79:0] rc_seq(input int lo, input int hi);
        logic [79:0] acc = '0;
        for (int k = lo; k <= hi; k++) if (lg_stb[k][0]) acc = {acc[71:0], lg_rc[k]};
        return acc;
    endfunction

    function automatic int cnt_busy(input int lo, input int hi);
        int c = 0;
        for (int k = lo; k <= hi; k++) if (lg_busy[k]) c++;
        return c;
    endfunction

    initial begin
        clr();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 80'({|{busy1, done1, rnd1, add1, sub1, shf1, mix1, key1, m1_1, m2_1, rc1}}), 80'd0);
        reset_n = 1'b1;
        $display("[TB] reset released");

        // Encrypt, NR=10
        clr(); s_start[0] = 1'b1;
        run(60, 1'b0);
        check("enc_first_add", 80'(lg_stb[1]), 80'(S_ADD));
        check("enc_round1_order", 80'(seq5(2)), 80'(ENC_RND));
        check("enc_rcon_seq", rc_seq(0, 59), ENC_RC);
        check("enc_mix_count", 80'(cnt_bit(1, 0, 59)), 80'd9);
        check("enc_strobe_count", 80'(cnt_bit(5, 0, 59)), 80'd50);
        check("enc_overlap", 80'(cnt_overlap(0, 59)), 80'd0);
        check("enc_last_add", 80'(lg_stb[50]), 80'(S_ADD));
        check("enc_done_cycle", 80'(first_done(0, 59)), 80'd51);
        check("enc_done_count", 80'(cnt_done(0, 59)), 80'd1);
        check("enc_busy_edges", 80'({lg_busy[0], lg_busy[1], lg_busy[50], lg_busy[51]}), 80'b0110);
        check("enc_busy_count", 80'(cnt_busy(0, 59)), 80'd50);
        check("enc_mux", 80'({lg_m1[1], lg_m2[1], lg_m1[2], lg_m2[2], lg_m1[47], lg_m2[47]}), 80'b0_00_1_01_1_10);
        $display("[TB] encrypt block checked");

        // Decrypt, NR=10
        clr(); s_start[0] = 1'b1; s_dec[0] = 1'b1;
        run(60, 1'b0);
        check("dec_round1_order", 80'(seq5(2)), 80'(DEC_RND));
        check("dec_final_round", 80'(seq5(47)), 80'({S_KEY, S_SHF, S_SUB, S_ADD, 5'b0}));
        check("dec_rcon_seq", rc_seq(0, 59), DEC_RC);
        check("dec_mix_final", 80'(cnt_bit(1, 47, 51)), 80'd0);
        check("dec_done_cycle", 80'(first_done(0, 59)), 80'd51);
        $display("[TB] decrypt block checked");

        // Stall for three cycles in round 4 (cycles 17..21 unstalled)
        clr(); s_start[0] = 1'b1; s_stall[18] = 1'b1; s_stall[19] = 1'b1; s_stall[20] = 1'b1;
        run(62, 1'b0);
        check("stall_before", 80'(lg_stb[18]), 80'(S_SUB));
        check("stall_gap", 80'(cnt_bit(5, 19, 21)), 80'd0);
        check("stall_resume", 80'(lg_stb[22]), 80'(S_SHF));
        check("stall_round_hold", 80'(lg_rnd[20]), 80'd4);
        check("stall_done_cycle", 80'(first_done(0, 61)), 80'd54);
        check("stall_strobe_count", 80'(cnt_bit(5, 0, 61)), 80'd50);
        $display("[TB] stall block checked");

        // Queued decrypt start during an encrypt block; third start ignored
        clr(); s_start[0] = 1'b1; s_start[20] = 1'b1; s_dec[20] = 1'b1; s_start[30] = 1'b1;
        run(160, 1'b0);
        check("queue_done1", 80'(first_done(0, 51)), 80'd51);
        check("queue_launch", 80'({lg_busy[51], lg_busy[52], lg_stb[52]}), 80'({1'b0, 1'b1, S_ADD}));
        check("queue_dec_order", 80'(seq5(53)), 80'(DEC_RND));
        check("queue_dec_rcon", rc_seq(52, 101), DEC_RC);
        check("queue_done2", 80'(first_done(52, 159)), 80'd102);
        check("queue_done_count", 80'(cnt_done(0, 159)), 80'd2);
        $display("[TB] queued start checked");

        // Abort in round 5 with a start pending
        clr(); s_start[0] = 1'b1; s_start[10] = 1'b1; s_abort[23] = 1'b1;
        run(80, 1'b0);
        check("abort_busy", 80'({lg_busy[23], lg_busy[24]}), 80'b10);
        check("abort_round", 80'(lg_rnd[24]), 80'd0);
        check("abort_no_strobes", 80'(cnt_bit(5, 24, 79)), 80'd0);
        check("abort_no_done", 80'(cnt_done(0, 79)), 80'd0);
        $display("[TB] abort checked");

        // Reset during round 3, then a fresh block
        clr(); s_start[0] = 1'b1; s_rst[13] = 1'b1; s_rst[14] = 1'b1; s_start[16] = 1'b1;
        run(75, 1'b0);
        check("rst_outputs", 80'({lg_any[14], lg_any[15], lg_any[16]}), 80'b000);
        check("rst_restart_add", 80'(lg_stb[17]), 80'(S_ADD));
        check("rst_restart_order", 80'(seq5(18)), 80'(ENC_RND));
        check("rst_done_cycle", 80'(first_done(14, 74)), 80'd67);
        check("rst_done_count", 80'(cnt_done(0, 74)), 80'd1);
        $display("[TB] reset recovery checked");

        // NR=2 instance
        clr(); s_start[0] = 1'b1;
        run(20, 1'b1);
        check("nr2_first_add", 80'(lg_stb[1]), 80'(S_ADD));
        check("nr2_round1", 80'(seq5(2)), 80'(ENC_RND));
        check("nr2_round2", 80'(seq5(7)), 80'({S_KEY, S_SUB, S_SHF, S_ADD, 5'b0}));
        check("nr2_mux2", 80'({lg_m2[1], lg_m2[2], lg_m2[7]}), 80'b00_01_10);
        check("nr2_mix_count", 80'(cnt_bit(1, 0, 19)), 80'd1);
        check("nr2_rcon", rc_seq(0, 19), 80'h0102);
        check("nr2_done_cycle", 80'(first_done(0, 19)), 80'd11);
        $display("[TB] NR=2 block checked");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
